// File: rtl/clk_div_mon.sv
// clk_div_mon
// -----------------------------------------------------------------------------
// Health monitor for an odd-ratio divided clock. The divided clock is sampled
// in the source clk domain. Each period and its high time are measured in clk
// cycles. Lock is declared after a run of correct periods. Wrong periods,
// stuck clocks and (optionally) duty faults set sticky error status.
//
// Parameters:
//   DIV      expected clk cycles per divided period (2..127)
//   CNT_W    measurement counter width, 2^CNT_W > 2*DIV
//   LOCK_CNT consecutive good periods needed for lock (1..15)
//   ERR_W    width of the saturating error counter
//
// Ports:
//   clk        in   source clock (also drives the divider)
//   rst        in   synchronous active-high reset
//   clk_div_in in   divided clock under test, asynchronous to clk
//   period     out  last measured period, 0 after a timeout
//   high_cnt   out  sampled-high cycles in the last period
//   period_vld out  one-cycle pulse when period/high_cnt update
//   locked     out  LOCK_CNT consecutive good periods, no failure since
//   err        out  sticky fault flag, cleared only by rst
//   err_cnt    out  saturating count of failed periods
//
// Optional feature macro: CLK_DIV_MON_DUTY_CHK_EN
//   When defined, a period is good only if the high and low sampled counts
//   differ by at most one cycle.
// -----------------------------------------------------------------------------
module clk_div_mon #(
    parameter int DIV      = 9,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] DIV_C     = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS      = 2'd2
    } state_t;

    state_t           state_reg;
    logic             s1_reg;
    logic             s2_reg;
    logic             s3_reg;
    logic [CNT_W-1:0] per_cnt_reg;
    logic [CNT_W-1:0] hi_cnt_reg;
    logic [3:0]       match_run_reg;

    logic             rise;
    logic             timeout;
    logic             duty_ok;
    logic             period_good;
    logic [3:0]       run_next;

    // s3 is the previous s2 sample; a rise is a 0->1 step of the synchronized
    // clock.
    assign rise = s2_reg & ~s3_reg;

    // A rise in the same cycle takes priority over the timeout.
    assign timeout = (per_cnt_reg == TIMEOUT_C) & ~rise;

`ifdef CLK_DIV_MON_DUTY_CHK_EN
    // Compare twice the high count with the period. This is the same as
    // comparing the high count with the low count. One extra bit keeps the
    // doubling exact.
    logic [CNT_W:0] twice_hi;
    logic [CNT_W:0] per_ext;
    logic [CNT_W:0] duty_diff;

    assign twice_hi = {hi_cnt_reg, 1'b0};
    assign per_ext  = {1'b0, per_cnt_reg};

    always_comb begin
        duty_diff = '0;
        if (twice_hi >= per_ext) begin
            duty_diff = twice_hi - per_ext;
        end else begin
            duty_diff = per_ext - twice_hi;
        end
        duty_ok = (duty_diff <= (CNT_W + 1)'(1));
    end
`else
    assign duty_ok = 1'b1;
`endif

    assign period_good = (per_cnt_reg == DIV_C) & duty_ok;

    // The match run saturates at LOCK_CNT.
    assign run_next = (match_run_reg >= LOCK_C) ? LOCK_C : match_run_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            s3_reg        <= 1'b0;
            per_cnt_reg   <= '0;
            hi_cnt_reg    <= '0;
            match_run_reg <= '0;
            period        <= '0;
            high_cnt      <= '0;
            period_vld    <= 1'b0;
            locked        <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= '0;
        end else begin
            s1_reg     <= clk_div_in;
            s2_reg     <= s1_reg;
            s3_reg     <= s2_reg;
            period_vld <= 1'b0;

            case (state_reg)
                IDLE: begin
                    state_reg <= WAIT_RISE;
                end

                WAIT_RISE: begin
                    if (rise) begin
                        per_cnt_reg <= ONE_C;
                        hi_cnt_reg  <= ONE_C;
                        state_reg   <= MEAS;
                    end
                end

                MEAS: begin
                    if (rise || timeout) begin
                        // On a rise the counters still hold the previous
                        // period, so the rise cycle is not counted in it.
                        period     <= rise ? per_cnt_reg : '0;
                        high_cnt   <= hi_cnt_reg;
                        period_vld <= 1'b1;

                        if (rise && period_good) begin
                            match_run_reg <= run_next;
                            if (run_next == LOCK_C) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_run_reg <= '0;
                            locked        <= 1'b0;
                            err           <= 1'b1;
                            if (err_cnt != {ERR_W{1'b1}}) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                        end

                        if (rise) begin
                            per_cnt_reg <= ONE_C;
                            hi_cnt_reg  <= ONE_C;
                        end else begin
                            state_reg <= WAIT_RISE;
                        end
                    end else begin
                        per_cnt_reg <= per_cnt_reg + ONE_C;
                        hi_cnt_reg  <= hi_cnt_reg + {{(CNT_W - 1){1'b0}}, s2_reg};
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_mon.sv
module tb_clk_div_mon;

    localparam int DIV      = 9;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_div_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    clk_div_mon #(
        .DIV      (DIV),
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .ERR_W    (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div_in (clk_div_in),
        .period     (period),
        .high_cnt   (high_cnt),
        .period_vld (period_vld),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model. It works on events: the input seen two clocks late,
    // rises on that sample stream, cycle distances between rises, and a
    // count of high samples. Mode: 0 idle, 1 waiting for rise, 2 measuring.
    int  n        = 0;
    bit  drv[$]   = '{1'b0, 1'b0, 1'b0};
    int  m_mode   = 0;
    int  m_start  = 0;
    int  m_hc     = 0;
    int  m_run    = 0;
    bit  m_vld    = 1'b0;
    bit  m_locked = 1'b0;
    bit  m_err    = 1'b0;
    int  m_period = 0;
    int  m_high   = 0;
    int  m_errcnt = 0;

    function automatic bit duty_ok(input int len, input int hc);
        int d;
        d = 2 * hc - len;
`ifdef CLK_DIV_MON_DUTY_CHK_EN
        return (d >= -1) && (d <= 1);
`else
        return (d == d);
`endif
    endfunction

    function automatic logic [26:0] got_vec();
        return {period_vld, period, high_cnt, locked, err, err_cnt};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {m_vld, 8'(m_period), 8'(m_high), m_locked, m_err, 8'(m_errcnt)};
    endfunction

    // Drive one clk cycle of input, advance the model, leave time at
    // posedge+1 for sampling.
    task automatic step(input bit v, input bit r);
        bit x;
        bit prev;
        bit rise;
        bit cap;
        bit good;
        int len;
        @(negedge clk);
        clk_div_in = v;
        rst        = r;
        @(posedge clk);
        n++;
        m_vld = 1'b0;
        if (r) begin
            drv      = '{1'b0, 1'b0, 1'b0};
            m_mode   = 0;
            m_run    = 0;
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_errcnt = 0;
            m_period = 0;
            m_high   = 0;
        end else begin
            drv.push_back(v);
            x    = drv[drv.size() - 3];
            prev = drv[drv.size() - 4];
            void'(drv.pop_front());
            rise = x && !prev;
            cap  = 1'b0;
            good = 1'b0;
            case (m_mode)
                0: m_mode = 1;
                1: if (rise) begin
                    m_mode  = 2;
                    m_start = n;
                    m_hc    = 1;
                end
                default: begin
                    len = n - m_start;
                    if (rise) begin
                        cap      = 1'b1;
                        m_period = len;
                        m_high   = m_hc;
                        good     = (len == DIV) && duty_ok(len, m_hc);
                        m_start  = n;
                        m_hc     = 1;
                    end else if (len == 2 * DIV) begin
                        cap      = 1'b1;
                        m_period = 0;
                        m_high   = m_hc;
                        m_mode   = 1;
                    end else begin
                        m_hc = m_hc + int'(x);
                    end
                end
            endcase
            if (cap) begin
                m_vld = 1'b1;
                if (good) begin
                    if (m_run < LOCK_CNT) m_run++;
                    m_locked = (m_run == LOCK_CNT);
                end else begin
                    m_run    = 0;
                    m_locked = 1'b0;
                    m_err    = 1'b1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
            end
            vectors++;
            if ({period_vld, locked, err} !== 3'b000 || period !== 8'd0 ||
                high_cnt !== 8'd0 || err_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_zero got=%h exp=0", got_vec());
            end
        end
    endtask

    task automatic test_clean_lock();
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 9; c++) begin
                step(c < 5, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL clean_lock step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if ({locked, err, err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL clean_lock_end got=%b/%b/%0d exp=1/0/0", locked, err, err_cnt);
        end
    endtask

    task automatic test_bad_period();
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < ((p == 0) ? 8 : 9); c++) begin
                step((p == 0) ? (c < 4) : (c < 5), 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL bad_period step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if ({locked, err, err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL bad_period_end got=%b/%b/%0d exp=1/1/1", locked, err, err_cnt);
        end
    endtask

    task automatic test_stuck();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 1'b0);
            if (period_vld) pulses++;
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL stuck step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
            end
        end
        vectors++;
        if (pulses !== 1 || period !== 8'd0 || locked !== 1'b0 || err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL stuck_end got=pulses %0d period %0d locked %b cnt %0d exp=1 0 0 2",
                     pulses, period, locked, err_cnt);
        end
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 9; c++) begin
                step(c < 5, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL stuck_recover step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_duty();
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < 9; c++) begin
                step(c < 7, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL duty step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
`ifdef CLK_DIV_MON_DUTY_CHK_EN
        if (locked !== 1'b0) begin
`else
        if (locked !== 1'b1) begin
`endif
            miscompares++;
            $display("FAIL duty_lock got=%b exp=%b", locked, m_locked);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1);
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < ((p < 3) ? 8 : 9); c++) begin
                step((p < 3) ? (c < 4) : (c < 5), 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL reset_mid_pre step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        vectors++;
        if ({locked, err_cnt} !== {1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL reset_mid_state got=%b/%0d exp=1/3", locked, err_cnt);
        end
        step(1'b1, 1'b1);
        vectors++;
        if (got_vec() !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_mid_clear got=%h exp=0", got_vec());
        end
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 9; c++) begin
                step(c < 5, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL reset_mid_post step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if ({locked, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_end got=%b/%b exp=1/0", locked, err);
        end
    endtask

    task automatic test_random();
        int h;
        int l;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(1, 0) == 0) begin
                h = 5;
                l = 4;
            end else begin
                h = $urandom_range(12, 1);
                l = $urandom_range(12, 1);
            end
            for (int c = 0; c < h + l; c++) begin
                step(c < h, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random step=%0d h=%0d l=%0d got=%h exp=%h",
                             n, h, l, got_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_saturate();
        step(1'b0, 1'b1);
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 8; c++) begin
                step(c < 4, 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL saturate step=%0d got=%h exp=%h", n, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (err_cnt !== 8'd255 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate_end got=%0d exp=255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_bad_period();
        test_stuck();
        test_duty();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
